// File: rtl/pll_seq_pkg.sv
// Shared state encoding and default timing constants for the PLL power sequencer.
// state_t values are exported unchanged on state_out for CSR readback.
package pll_seq_pkg;

  typedef enum logic [3:0] {
    ST_WAIT_LOCK     = 4'd0,
    ST_LOCK_STABLE   = 4'd1,
    ST_SWITCH_TO_PLL = 4'd2,
    ST_RUN           = 4'd3,
    ST_DRAIN         = 4'd4,
    ST_SWITCH_TO_SPI = 4'd5,
    ST_RECOVER       = 4'd6,
    ST_OFF           = 4'd7,
    ST_RETRY_OFF     = 4'd8,
    ST_FAULT         = 4'd9
  } state_t;

  localparam int unsigned DEF_SETTLE_CYCLES       = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES  = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES = 4096;
  localparam int unsigned DEF_MAX_RETRIES         = 3;

endpackage

// File: rtl/cdc_sync_bit.sv
// Two-flop synchroniser for a single asynchronous level into the osc_clock domain.
module cdc_sync_bit #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_power_sequencer.sv
// Sequences PLL power-down/wake, the image-buffer DCS select and the PLL-domain reset gate.
// All outputs are registered and decoded from the next state.
module pll_power_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES       = DEF_SETTLE_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       clock_in,
  input  logic       reset_n_in,
  input  logic       sleep_request_in,
  input  logic       capture_busy_in,
  input  logic       pll_locked_in,
  output logic       pllpowerdown_n_out,
  output logic       image_buffer_read_en_out,
  output logic       domain_reset_n_out,
  output logic       sleep_ack_out,
  output logic       error_out,
  output logic       lock_lost_out,
  output logic [1:0] retry_count_out,
  output logic [3:0] state_out
);

  localparam int unsigned CW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

  logic sleep_sync, busy_sync, lock_sync;

  cdc_sync_bit #(.RESET_VALUE(1'b0)) u_sync_sleep (
    .clk(clock_in), .rst_n(reset_n_in), .d(sleep_request_in), .q(sleep_sync));
  cdc_sync_bit #(.RESET_VALUE(1'b0)) u_sync_busy (
    .clk(clock_in), .rst_n(reset_n_in), .d(capture_busy_in), .q(busy_sync));
  cdc_sync_bit #(.RESET_VALUE(1'b0)) u_sync_lock (
    .clk(clock_in), .rst_n(reset_n_in), .d(pll_locked_in), .q(lock_sync));

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    retry, retry_next;
  logic          lock_lost, lock_lost_next;
  logic          settled;
  logic          pd_n_next, rd_en_next, rst_n_next, ack_next, err_next;
  logic          pd_n_q, rd_en_q, rst_n_q, ack_q, err_q;

  always_comb begin
    state_next     = state;
    retry_next     = retry;
    lock_lost_next = lock_lost;
    settled        = (cnt == SETTLE_LAST);

    unique case (state)
      ST_WAIT_LOCK: begin
        if (lock_sync) begin
          state_next = ST_LOCK_STABLE;
        end else if (cnt == TIMEOUT_LAST) begin
          if (32'(retry) < MAX_RETRIES) begin
            retry_next = retry + 2'd1;
            state_next = ST_RETRY_OFF;
          end else begin
            state_next = ST_FAULT;
          end
        end
      end
      ST_LOCK_STABLE: begin
        if (!lock_sync)               state_next = ST_WAIT_LOCK;
        else if (cnt == STABLE_LAST)  state_next = ST_SWITCH_TO_PLL;
      end
      ST_SWITCH_TO_PLL: begin
        // Lock loss is acted on from the second cycle so the DCS select never flips back-to-back.
        if (!lock_sync && cnt != '0) begin
          state_next = ST_RECOVER;
        end else if (settled) begin
          state_next = ST_RUN;
          retry_next = '0;
        end
      end
      ST_RUN: begin
        if (!lock_sync) begin
          lock_lost_next = 1'b1;
          state_next     = ST_RECOVER;
        end else if (sleep_sync) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!lock_sync) begin
          lock_lost_next = 1'b1;
          state_next     = ST_RECOVER;
        end else if (!sleep_sync) begin
          state_next = ST_RUN;
        end else if (!busy_sync) begin
          state_next = ST_SWITCH_TO_SPI;
        end
      end
      ST_SWITCH_TO_SPI: if (settled) state_next = ST_OFF;
      ST_RECOVER:       if (settled) state_next = ST_WAIT_LOCK;
      ST_OFF: begin
        if (cnt >= SETTLE_LAST && !sleep_sync) begin
          state_next = ST_WAIT_LOCK;
          retry_next = '0;
        end
      end
      ST_RETRY_OFF:     if (settled) state_next = ST_WAIT_LOCK;
      ST_FAULT:         if (sleep_sync) state_next = ST_OFF;
      default:          state_next = ST_WAIT_LOCK;
    endcase

    if (state_next == ST_OFF && state != ST_OFF) lock_lost_next = 1'b0;

    cnt_next = cnt;
    if (state_next != state)  cnt_next = '0;
    else if (cnt != '1)       cnt_next = cnt + 1'b1;

    pd_n_next  = !(state_next inside {ST_OFF, ST_RETRY_OFF, ST_FAULT});
    rd_en_next = !(state_next inside {ST_SWITCH_TO_PLL, ST_RUN, ST_DRAIN});
    rst_n_next = (state_next inside {ST_RUN, ST_DRAIN});
    ack_next   = (state_next == ST_OFF);
    err_next   = (state_next == ST_FAULT);
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state     <= ST_WAIT_LOCK;
      cnt       <= '0;
      retry     <= '0;
      lock_lost <= 1'b0;
      pd_n_q    <= 1'b1;
      rd_en_q   <= 1'b1;
      rst_n_q   <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      retry     <= retry_next;
      lock_lost <= lock_lost_next;
      pd_n_q    <= pd_n_next;
      rd_en_q   <= rd_en_next;
      rst_n_q   <= rst_n_next;
      ack_q     <= ack_next;
      err_q     <= err_next;
    end
  end

  assign pllpowerdown_n_out       = pd_n_q;
  assign image_buffer_read_en_out = rd_en_q;
  assign domain_reset_n_out       = rst_n_q;
  assign sleep_ack_out            = ack_q;
  assign error_out                = err_q;
  assign lock_lost_out            = lock_lost;
  assign retry_count_out          = retry;
  assign state_out                = state;

endmodule

// File: tb/tb_pll_power_sequencer.sv
// Directed bench for pll_power_sequencer: power-up, sleep/wake, lock glitches, retries/fault, async reset.
// Cycle numbers count rising edges after reset release; inputs change and outputs are sampled 1 unit after an edge.
module tb_pll_power_sequencer;

  localparam logic [31:0] S_WAIT = 0, S_STABLE = 1, S_SW_PLL = 2, S_RUN = 3, S_DRAIN = 4;
  localparam logic [31:0] S_SW_SPI = 5, S_RECOVER = 6, S_OFF = 7, S_RETRY_OFF = 8, S_FAULT = 9;

  logic       clk = 1'b0;
  logic       rst_n, sleep, busy, lock;
  logic       pd_n, rd_en, dom_rst_n, ack, err, lock_lost;
  logic [1:0] retry;
  logic [3:0] state;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;

  pll_power_sequencer #(
    .SETTLE_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES(2)
  ) dut (
    .clock_in                 (clk),
    .reset_n_in               (rst_n),
    .sleep_request_in         (sleep),
    .capture_busy_in          (busy),
    .pll_locked_in            (lock),
    .pllpowerdown_n_out       (pd_n),
    .image_buffer_read_en_out (rd_en),
    .domain_reset_n_out       (dom_rst_n),
    .sleep_ack_out            (ack),
    .error_out                (err),
    .lock_lost_out            (lock_lost),
    .retry_count_out          (retry),
    .state_out                (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
  endtask

  task automatic chk_outs(input string tag, input logic p, input logic r, input logic d);
    chk({tag, ".pd_n"},  32'(pd_n),      32'(p));
    chk({tag, ".rd_en"}, 32'(rd_en),     32'(r));
    chk({tag, ".rst_n"}, 32'(dom_rst_n), 32'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int unsigned n);
    while (cyc < n) step();
  endtask

  initial begin
    rst_n = 1'b0; sleep = 1'b0; busy = 1'b0; lock = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 1'b1, 1'b1, 1'b0);
    chk("reset.state", 32'(state), S_WAIT);
    chk("reset.ack", 32'(ack), 0);
    chk("reset.err", 32'(err), 0);
    chk("reset.lock_lost", 32'(lock_lost), 0);
    chk("reset.retry", 32'(retry), 0);
    rst_n = 1'b1;
    cyc = 0;

    // Power-up: lock at 10 -> LOCK_STABLE at 13, SWITCH_TO_PLL at 21, RUN at 25
    goto(10); lock = 1'b1;
    goto(20); chk("pwr.pre_switch.state", 32'(state), S_STABLE);
    chk("pwr.pre_switch.rd_en", 32'(rd_en), 1);
    goto(21); chk_outs("pwr.switch", 1'b1, 1'b0, 1'b0);
    chk("pwr.switch.state", 32'(state), S_SW_PLL);
    goto(24); chk("pwr.pre_run.rst_n", 32'(dom_rst_n), 0);
    goto(25); chk_outs("pwr.run", 1'b1, 1'b0, 1'b1);
    chk("pwr.run.state", 32'(state), S_RUN);

    // Sleep while busy
    sleep = 1'b1; busy = 1'b1;
    goto(27); chk("sleep.pre_drain.state", 32'(state), S_RUN);
    goto(28); chk("sleep.drain.state", 32'(state), S_DRAIN);
    chk_outs("sleep.drain", 1'b1, 1'b0, 1'b1);
    goto(45); busy = 1'b0;
    goto(47); chk("sleep.still_drain.state", 32'(state), S_DRAIN);
    goto(48); chk_outs("sleep.sw_spi", 1'b1, 1'b1, 1'b0);
    chk("sleep.sw_spi.state", 32'(state), S_SW_SPI);
    goto(51); chk("sleep.pre_off.pd_n", 32'(pd_n), 1);
    chk("sleep.pre_off.ack", 32'(ack), 0);
    goto(52); chk("sleep.off.pd_n", 32'(pd_n), 0);
    chk("sleep.off.ack", 32'(ack), 1);
    chk("sleep.off.state", 32'(state), S_OFF);

    // Wake: sleep drops on OFF entry, minimum off time still enforced
    sleep = 1'b0; lock = 1'b0;
    goto(55); chk("wake.min_off.pd_n", 32'(pd_n), 0);
    goto(56); chk("wake.pd_n", 32'(pd_n), 1);
    chk("wake.state", 32'(state), S_WAIT);
    chk("wake.ack", 32'(ack), 0);
    goto(61); lock = 1'b1;
    goto(63); chk("wake.pre_stable.state", 32'(state), S_WAIT);
    goto(64); chk("wake.stable.state", 32'(state), S_STABLE);
    goto(76); chk("wake.run.state", 32'(state), S_RUN);
    chk("wake.run.retry", 32'(retry), 0);
    chk("wake.run.lock_lost", 32'(lock_lost), 0);
    chk("wake.run.rst_n", 32'(dom_rst_n), 1);

    // Lock drop in RUN
    lock = 1'b0;
    goto(78); chk("drop.pre.lock_lost", 32'(lock_lost), 0);
    goto(79); chk("drop.recover.state", 32'(state), S_RECOVER);
    chk("drop.recover.lock_lost", 32'(lock_lost), 1);
    chk_outs("drop.recover", 1'b1, 1'b1, 1'b0);
    goto(82); chk("drop.still_recover.state", 32'(state), S_RECOVER);
    goto(83); chk("drop.wait.state", 32'(state), S_WAIT);
    chk("drop.wait.lock_lost", 32'(lock_lost), 1);

    // One-cycle lock glitch during LOCK_STABLE restarts the stable count
    lock = 1'b1;
    goto(86); chk("glitch.stable.state", 32'(state), S_STABLE);
    goto(91); lock = 1'b0;
    goto(92); lock = 1'b1;
    goto(93); chk("glitch.pre.state", 32'(state), S_STABLE);
    goto(94); chk("glitch.wait.state", 32'(state), S_WAIT);
    chk("glitch.retry", 32'(retry), 0);
    goto(95); chk("glitch.restable.state", 32'(state), S_STABLE);
    goto(102); chk("glitch.no_early_switch.rd_en", 32'(rd_en), 1);
    goto(103); chk("glitch.switch.state", 32'(state), S_SW_PLL);
    goto(107); chk("glitch.run.state", 32'(state), S_RUN);

    // Sleep withdrawn in DRAIN: rd_en must stay low throughout
    sleep = 1'b1; busy = 1'b1;
    for (int unsigned c = 107; c <= 115; c++) begin
      chk("withdraw.rd_en", 32'(rd_en), 0);
      if (cyc == 110) begin
        chk("withdraw.drain.state", 32'(state), S_DRAIN);
        sleep = 1'b0;
      end
      if (cyc == 113) begin
        chk("withdraw.run.state", 32'(state), S_RUN);
        sleep = 1'b1; busy = 1'b0;
      end
      step();
    end

    // Down to OFF again: lock_lost clears on OFF entry
    goto(120); chk("off2.sw_spi.state", 32'(state), S_SW_SPI);
    chk("off2.pre.lock_lost", 32'(lock_lost), 1);
    goto(121); chk("off2.state", 32'(state), S_OFF);
    chk("off2.lock_lost", 32'(lock_lost), 0);
    chk("off2.ack", 32'(ack), 1);
    lock = 1'b0;

    // Asynchronous reset in OFF, mid-cycle
    goto(122); chk("areset.pre.pd_n", 32'(pd_n), 0);
    #2; rst_n = 1'b0; #1;
    chk_outs("areset", 1'b1, 1'b1, 1'b0);
    chk("areset.ack", 32'(ack), 0);
    chk("areset.state", 32'(state), S_WAIT);
    sleep = 1'b0;
    goto(124); rst_n = 1'b1;

    // No lock: timeouts at 156 and 192, FAULT at 228
    goto(155); chk("nolock.pre_to.state", 32'(state), S_WAIT);
    goto(156); chk("nolock.to1.state", 32'(state), S_RETRY_OFF);
    chk("nolock.to1.retry", 32'(retry), 1);
    chk_outs("nolock.to1", 1'b0, 1'b1, 1'b0);
    goto(159); chk("nolock.off_pulse.pd_n", 32'(pd_n), 0);
    goto(160); chk("nolock.repower.pd_n", 32'(pd_n), 1);
    chk("nolock.repower.state", 32'(state), S_WAIT);
    goto(192); chk("nolock.to2.state", 32'(state), S_RETRY_OFF);
    chk("nolock.to2.retry", 32'(retry), 2);
    goto(196); chk("nolock.wait3.state", 32'(state), S_WAIT);
    goto(227); chk("nolock.pre_fault.err", 32'(err), 0);
    goto(228); chk("fault.state", 32'(state), S_FAULT);
    chk("fault.err", 32'(err), 1);
    chk("fault.retry", 32'(retry), 2);
    chk_outs("fault", 1'b0, 1'b1, 1'b0);

    // Leave FAULT through OFF
    goto(230); sleep = 1'b1;
    goto(232); chk("fault.hold.state", 32'(state), S_FAULT);
    goto(233); chk("fault_off.state", 32'(state), S_OFF);
    chk("fault_off.err", 32'(err), 0);
    chk("fault_off.ack", 32'(ack), 1);
    goto(234); sleep = 1'b0;
    goto(236); chk("fault_wake.pre.state", 32'(state), S_OFF);
    goto(237); chk("fault_wake.state", 32'(state), S_WAIT);
    chk("fault_wake.err", 32'(err), 0);
    chk("fault_wake.retry", 32'(retry), 0);
    chk("fault_wake.pd_n", 32'(pd_n), 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
